// File: rtl/proc_bus_responder.sv
// Memory/IO responder for the processor bus: RAM, LED register, synchronized
// switch port and a byte FIFO drained over valid/ready, all with 1-cycle registered reads.
module proc_bus_responder #(
    parameter int RAM_ADDR_W = 8,
    parameter int FIFO_DEPTH = 8,
    parameter int SW_W       = 10,
    parameter int LED_W      = 10
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [15:0]      ADDR,
    input  logic [15:0]      DOUT,
    input  logic             W,
    output logic [15:0]      DIN,
    input  logic [SW_W-1:0]  SW,
    output logic [LED_W-1:0] LEDR,
    output logic [7:0]       tx_data,
    output logic             tx_valid,
    input  logic             tx_ready
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    typedef enum logic [3:0] {
        REGION_RAM  = 4'h0,
        REGION_LED  = 4'h1,
        REGION_SW   = 4'h3,
        REGION_FIFO = 4'h4
    } region_e;

    logic [15:0]           ram [2**RAM_ADDR_W];
    logic [7:0]            fifo_mem [FIFO_DEPTH];
    logic [RAM_ADDR_W-1:0] ram_idx;
    logic [SW_W-1:0]       sw_meta;
    logic [SW_W-1:0]       sw_sync;
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W-1:0]      rd_next;
    logic [4:0]            count;
    logic                  overflow;
    logic                  full;
    logic                  empty;
    logic                  sel_ram;
    logic                  sel_led;
    logic                  sel_fifo;
    logic                  push;
    logic                  pop;
    logic                  accept;
    logic                  clear_ovf;
    logic [15:0]           read_value;
    logic                  unused_addr_bits;

    // Address bits between the RAM index and the region nibble are don't-care.
    assign unused_addr_bits = ^ADDR[11:RAM_ADDR_W];

    assign ram_idx   = ADDR[RAM_ADDR_W-1:0];
    assign sel_ram   = (ADDR[15:12] == REGION_RAM);
    assign sel_led   = (ADDR[15:12] == REGION_LED);
    assign sel_fifo  = (ADDR[15:12] == REGION_FIFO);

    assign full      = (count == 5'(FIFO_DEPTH));
    assign empty     = (count == 5'd0);
    assign tx_valid  = !empty;
    assign push      = W && sel_fifo && !ADDR[0];
    assign clear_ovf = W && sel_fifo && ADDR[0] && DOUT[0];
    assign pop       = tx_valid && tx_ready;
    // A push into a full FIFO only lands if the head leaves in the same cycle.
    assign accept    = push && (!full || pop);
    assign rd_next   = rd_ptr + 1'b1;

    always_comb begin
        read_value = '0;
        case (ADDR[15:12])
            REGION_RAM:  read_value = ram[ram_idx];
            REGION_LED:  read_value = 16'(LEDR);
            REGION_SW:   read_value = 16'(sw_sync);
            REGION_FIFO: read_value = {overflow, full, empty, 8'b0, count};
            default:     read_value = '0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values; that is also what gives read-before-write on DIN.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            DIN     <= '0;
            LEDR    <= '0;
            sw_meta <= '0;
            sw_sync <= '0;
        end else begin
            DIN     <= read_value;
            sw_meta <= SW;
            sw_sync <= sw_meta;
            if (W && sel_led)
                LEDR <= DOUT[LED_W-1:0];
        end
    end

    // NOTE: storage arrays carry no reset so they map onto RAM primitives;
    // RAM contents deliberately survive Reset, FIFO slots are invalidated by the pointers.
    always_ff @(posedge Clock) begin
        if (W && sel_ram)
            ram[ram_idx] <= DOUT;
        if (accept)
            fifo_mem[wr_ptr] <= DOUT[7:0];
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            tx_data  <= '0;
        end else begin
            if (accept)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_next;

            case ({accept, pop})
                2'b10:   count <= count + 5'd1;
                2'b01:   count <= count - 5'd1;
                default: count <= count;
            endcase

            // A dropped push outranks a simultaneous clear.
            if (push && full && !pop)
                overflow <= 1'b1;
            else if (clear_ovf)
                overflow <= 1'b0;

            // tx_data is the registered head; the slot behind the head is only
            // valid in memory when more than one entry is queued.
            if (accept && empty)
                tx_data <= DOUT[7:0];
            else if (pop) begin
                if (count > 5'd1)
                    tx_data <= fifo_mem[rd_next];
                else if (accept)
                    tx_data <= DOUT[7:0];
            end
        end
    end

endmodule

// File: tb/tb_proc_bus_responder.sv
// Directed self-checking bench for proc_bus_responder: RAM, LED, switch sync,
// FIFO push/pop/overflow/wrap, full-with-pop and reset mid-traffic.
module tb_proc_bus_responder;

    logic        Clock;
    logic        Reset;
    logic [15:0] ADDR;
    logic [15:0] DOUT;
    logic        W;
    logic [15:0] DIN;
    logic [9:0]  SW;
    logic [9:0]  LEDR;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;

    int checks_total  = 0;
    int checks_passed = 0;

    proc_bus_responder #(
        .RAM_ADDR_W (8),
        .FIFO_DEPTH (8),
        .SW_W       (10),
        .LED_W      (10)
    ) dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .ADDR     (ADDR),
        .DOUT     (DOUT),
        .W        (W),
        .DIN      (DIN),
        .SW       (SW),
        .LEDR     (LEDR),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks_total++;
        if (got === exp)
            checks_passed++;
        else
            $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic cycle();
        @(posedge Clock);
        #1;
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] d);
        ADDR = a;
        DOUT = d;
        W    = 1'b1;
        cycle();
        W    = 1'b0;
    endtask

    task automatic rd(input logic [15:0] a, output logic [15:0] d);
        ADDR = a;
        W    = 1'b0;
        cycle();
        d    = DIN;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] v;

        Reset = 1'b1; W = 1'b0; ADDR = '0; DOUT = '0; SW = '0; tx_ready = 1'b0;
        cycle();
        cycle();
        Reset = 1'b0;

        check("reset_din", DIN, 16'h0000);
        check("reset_ledr", 16'(LEDR), 16'h0000);
        check("reset_tx_valid", 16'(tx_valid), 16'h0000);
        check("reset_tx_data", 16'(tx_data), 16'h0000);
        rd(16'h4000, v); check("reset_status", v, 16'h2000);

        // RAM: read-before-write on collision, then aliasing through ignored bits
        wr(16'h0005, 16'h1111);
        wr(16'h0005, 16'hBEEF);
        check("ram_write_cycle_old", DIN, 16'h1111);
        rd(16'h0005, v); check("ram_read", v, 16'hBEEF);
        rd(16'h0105, v); check("ram_alias", v, 16'hBEEF);
        wr(16'h2005, 16'h0000);
        rd(16'h0005, v); check("ram_unmapped_write", v, 16'hBEEF);
        rd(16'h2000, v); check("unmapped_read_2", v, 16'h0000);
        rd(16'hF000, v); check("unmapped_read_f", v, 16'h0000);

        // LED register
        wr(16'h1000, 16'h03FF);
        check("led_value", 16'(LEDR), 16'h03FF);
        rd(16'h1000, v); check("led_read", v, 16'h03FF);
        wr(16'h1000, 16'hF0A5);
        check("led_truncate", 16'(LEDR), 16'h00A5);

        // Switch synchronizer: two flops, then the registered read
        SW = 10'h2A5;
        cycle(); cycle(); cycle();
        rd(16'h3000, v); check("sw_read", v, 16'h02A5);
        wr(16'h3000, 16'hFFFF);
        rd(16'h3000, v); check("sw_write_ignored", v, 16'h02A5);
        check("sw_write_led", 16'(LEDR), 16'h00A5);
        SW = 10'h155;
        rd(16'h3000, v); check("sw_sync_edge1", v, 16'h02A5);
        rd(16'h3000, v); check("sw_sync_edge2", v, 16'h02A5);
        rd(16'h3000, v); check("sw_sync_edge3", v, 16'h0155);

        // FIFO basic
        rd(16'h4000, v); check("fifo_status_empty", v, 16'h2000);
        check("fifo_valid_before", 16'(tx_valid), 16'h0000);
        wr(16'h4000, 16'h0041);
        check("fifo_valid_after_push", 16'(tx_valid), 16'h0001);
        check("fifo_head_41", 16'(tx_data), 16'h0041);
        wr(16'h4000, 16'h0042);
        check("fifo_head_still_41", 16'(tx_data), 16'h0041);
        rd(16'h4000, v); check("fifo_status_two", v, 16'h0002);
        tx_ready = 1'b1;
        cycle();
        check("fifo_pop_head_42", 16'(tx_data), 16'h0042);
        check("fifo_pop_valid", 16'(tx_valid), 16'h0001);
        cycle();
        check("fifo_drained", 16'(tx_valid), 16'h0000);
        tx_ready = 1'b0;
        rd(16'h4001, v); check("fifo_status_odd_addr", v, 16'h2000);

        // Overflow: 9 pushes into 8 slots, pointers wrap from index 2
        for (int i = 0; i < 9; i++)
            wr(16'h4000, 16'(16'h0010 + i));
        rd(16'h4000, v); check("ovf_status", v, 16'hC008);
        wr(16'h4001, 16'h0002);
        check("ovf_clear_wcycle_din", DIN, 16'hC008);
        rd(16'h4000, v); check("ovf_no_clear_bit0_0", v, 16'hC008);
        wr(16'h4001, 16'h0001);
        rd(16'h4001, v); check("ovf_cleared", v, 16'h4008);
        tx_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("ovf_drain_valid_%0d", i), 16'(tx_valid), 16'h0001);
            check($sformatf("ovf_drain_data_%0d", i), 16'(tx_data), 16'(16'h0010 + i));
            cycle();
        end
        check("ovf_drain_empty", 16'(tx_valid), 16'h0000);
        tx_ready = 1'b0;

        // Full with a simultaneous pop: both happen, no overflow
        for (int i = 0; i < 8; i++)
            wr(16'h4000, 16'(16'h0060 + i));
        rd(16'h4000, v); check("full_status", v, 16'h4008);
        ADDR = 16'h4000; DOUT = 16'h0055; W = 1'b1; tx_ready = 1'b1;
        cycle();
        W = 1'b0; tx_ready = 1'b0;
        check("full_pop_head", 16'(tx_data), 16'h0061);
        rd(16'h4000, v); check("full_pop_status", v, 16'h4008);
        tx_ready = 1'b1;
        for (int i = 1; i < 9; i++) begin
            check($sformatf("full_drain_%0d", i), 16'(tx_data),
                  (i == 8) ? 16'h0055 : 16'(16'h0060 + i));
            cycle();
        end
        check("full_drain_empty", 16'(tx_valid), 16'h0000);
        tx_ready = 1'b0;

        // Push and pop together while partially filled
        wr(16'h4000, 16'h0070);
        wr(16'h4000, 16'h0071);
        ADDR = 16'h4000; DOUT = 16'h0072; W = 1'b1; tx_ready = 1'b1;
        cycle();
        W = 1'b0; tx_ready = 1'b0;
        check("pushpop_head", 16'(tx_data), 16'h0071);
        rd(16'h4000, v); check("pushpop_status", v, 16'h0002);

        // Reset mid-traffic: one more push makes three queued bytes
        wr(16'h4000, 16'h00A1);
        wr(16'h1000, 16'h00F0);
        wr(16'h0007, 16'h1234);
        check("pre_reset_ledr", 16'(LEDR), 16'h00F0);
        rd(16'h4000, v); check("pre_reset_status", v, 16'h0003);
        ADDR = 16'h0007;
        Reset = 1'b1;
        cycle();
        Reset = 1'b0;
        check("mid_reset_din", DIN, 16'h0000);
        check("mid_reset_ledr", 16'(LEDR), 16'h0000);
        check("mid_reset_tx_valid", 16'(tx_valid), 16'h0000);
        check("mid_reset_tx_data", 16'(tx_data), 16'h0000);
        rd(16'h3000, v); check("mid_reset_sw_sync", v, 16'h0000);
        rd(16'h4000, v); check("mid_reset_status", v, 16'h2000);
        rd(16'h0007, v); check("ram_retained", v, 16'h1234);
        rd(16'h0005, v); check("ram_retained_5", v, 16'hBEEF);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule

// File: doc/proc_bus_responder.md
Name: proc_bus_responder

Overview:
- Memory/IO responder on the processor's memory bus (ADDR, DOUT, W out of the processor; DIN back into it).
- Decodes each access into one of four regions: program/data RAM, an LED register, a switch input port, and a byte output FIFO.
- Returns registered read data one cycle after the address is presented. This matches the processor's single wait cycle for synchronous memory.
- The FIFO is drained by an external consumer through a valid/ready handshake.

Parameters:
- RAM_ADDR_W, 8, RAM word-address width; RAM holds 2^RAM_ADDR_W 16-bit words.
- FIFO_DEPTH, 8, output FIFO entries; power of two, 2..16.
- SW_W, 10, switch input width.
- LED_W, 10, LED register width.

Ports:
- Clock  in  1  system clock; all state updates on rising edge.
- Reset  in  1  synchronous reset, active-high.
- ADDR  in  16  processor address, stable for the whole cycle.
- DOUT  in  16  processor write data.
- W  in  1  write strobe; a write occurs at any rising edge where W=1.
- DIN  out  16  registered read data to processor.
- SW  in  SW_W  asynchronous switch inputs.
- LEDR  out  LED_W  LED register.
- tx_data  out  8  FIFO head byte.
- tx_valid  out  1  FIFO non-empty.
- tx_ready  in  1  consumer accepts head byte.

Behaviour:
- One clock, synchronous active-high reset.
- Reset values:
  - DIN=0, LEDR=0, tx_valid=0, tx_data=0.
  - FIFO pointers and count = 0; overflow flag = 0.
  - Switch synchronizer flops = 0.
  - RAM contents are not reset and are preserved across Reset.
- Decode is on ADDR[15:12]:
  - 0x0 = RAM, word index ADDR[RAM_ADDR_W-1:0]; upper bits are ignored, so aliasing is intended.
  - 0x1 = LED register.
  - 0x3 = switch port.
  - 0x4 = FIFO.
  - All other values are unmapped.
- Read timing:
  - Every rising edge, DIN <= read value for the ADDR present at that edge, regardless of W.
  - Read latency is exactly 1 cycle.
- Read values:
  - RAM: word at index.
  - LED: zero-extended LEDR.
  - Switch: zero-extended output of the 2-flop SW synchronizer as sampled at that edge.
  - FIFO (either ADDR[0]): status {overflow, full, empty, 8'b0, count[4:0]} in bits 15,14,13,12:5 (zero),4:0.
  - Unmapped: 0.
- Read/write collision: on a write cycle, DIN returns the pre-write value (read-before-write), including for RAM at the same index.
- Write effects when W=1:
  - RAM: mem[index] <= DOUT.
  - LED: LEDR <= DOUT[LED_W-1:0].
  - Switch region and unmapped: ignored.
  - FIFO with ADDR[0]=0: push DOUT[7:0].
  - FIFO with ADDR[0]=1: if DOUT[0]=1, clear overflow; no push.
- FIFO organisation:
  - Circular buffer of FIFO_DEPTH bytes; read and write pointers wrap modulo FIFO_DEPTH.
  - count range is 0..FIFO_DEPTH.
  - full = (count == FIFO_DEPTH); empty = (count == 0).
- FIFO outputs:
  - tx_data = head entry; tx_valid = !empty.
  - No fall-through: a push into an empty FIFO raises tx_valid on the next cycle.
- FIFO pop:
  - A pop occurs when tx_valid && tx_ready at the edge; the head advances.
  - tx_data may change only after a pop or after a push into an empty FIFO.
- Push while full, no simultaneous pop: the byte is dropped, overflow <= 1 (sticky), and count is unchanged.
- Push while full with a simultaneous pop: both occur; count stays FIFO_DEPTH and overflow is unchanged.
- Push and pop in the same cycle when non-empty and not full: count unchanged, both pointers advance.
- Overflow set and clear in the same cycle: cannot arise from one write. If a clear coincides with a dropped push from an earlier-latched condition, set wins.
- Reset mid-operation: any in-flight read returns DIN=0 next cycle. FIFO contents are discarded, but RAM contents are retained.

Test Plan:
- RAM write then read: W=1 ADDR=0x0005 DOUT=0xBEEF; next cycle ADDR=0x0005 W=0 -> DIN=0xBEEF one cycle later. Write-cycle DIN shows the old value. ADDR=0x0105 aliases to the same word.
- LED and switch: write 0x03FF to 0x1000 -> LEDR=0x3FF, read 0x1000 -> DIN=0x03FF. Set SW=0x2A5 -> read of 0x3000 issued 2+ cycles later returns 0x02A5. Write to 0x3000 has no effect.
- FIFO basic, tx_ready=0: push 0x41, 0x42 -> tx_valid rises the cycle after the first push, tx_data=0x41. Status read -> 0x2000 before the pushes, 0x0002 after. Raise tx_ready -> pops 0x41 then 0x42, then tx_valid=0.
- FIFO overflow, tx_ready=0: 9 pushes of 0x10..0x18 -> status 0xC008; 0x18 is lost. Write DOUT=1 to 0x4001 -> status 0x4008. Drain yields 0x10..0x17 in order, with the pointer wrap exercised.
- Full with simultaneous pop: fill to 8, then push 0x55 with tx_ready=1 in the same cycle -> count stays 8, overflow stays 0, and 0x55 appears last in the drain.
- Reset mid-traffic: 3 bytes queued, LEDR=0x0F0, RAM[7]=0x1234; pulse Reset for 1 cycle -> DIN=0, LEDR=0, tx_valid=0, status=0x2000. Read of RAM[7] still returns 0x1234.
